dragon_v3_main_12: RTL and testbench



---
 rtl/dragon_v3_main_12.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_dragon_v3_main_12.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dragon_v3_main_12.sv
// Dragon v3 DRS4 readout control core (50 MHz OSC domain).
// Sequences the eight DRS4 chips through INIT, PLL-lock wait, domino
// sampling, trigger stop and serial readout. Generates DRS_REFCLK,
// AD9222_CLK and the status LEDs. Every pin of the sibling blocks
// (Ethernet, slow control, EEPROM, DACs) is held inactive.
// Optional feature: define DRS_AUTO_TRIG_EN to add an internal periodic
// trigger source, OR'd with the external L1 trigger edge.
module dragon_v3_main_12 #(
    parameter int NSAMPLES         = 1024,
    parameter int STOP_DELAY       = 8,
    parameter int RESET_CYCLES     = 8,
    parameter int REFCLK_DIV       = 25,
    parameter int AUTO_TRIG_PERIOD = 50000
) (
    input  logic       OSC,
    input  logic [7:0] DIP_SWITCH,
    input  logic [7:0] DRS_PLLLCK,
    input  logic       L1_OUT_P,
    input  logic       L1_OUT_N,
    output logic [7:0] DRS_RESETn,
    output logic [7:0] DRS_DENABLE,
    output logic [7:0] DRS_DWRITE,
    output logic [7:0] DRS_RSRLOAD,
    output logic [7:0] DRS_SRCLK,
    output logic [3:0] DRS_A0,
    output logic [3:0] DRS_A1,
    output logic [3:0] DRS_A2,
    output logic [3:0] DRS_A3,
    output logic [3:0] DRS_A4,
    output logic [3:0] DRS_A5,
    output logic [3:0] DRS_A6,
    output logic [3:0] DRS_A7,
    output logic [7:0] DRS_REFCLK_P,
    output logic [7:0] DRS_REFCLK_N,
    output logic       AD9222_CLK_P,
    output logic       AD9222_CLK_N,
    output logic       TRIG_BPOUT_P,
    output logic       TRIG_BPOUT_N,
    output logic [1:0] LED,
    output logic [7:0] DRS_WSRIN,
    output logic [7:0] DRS_SRIN,
    output logic       L0_CTR,
    output logic       TRIG_A0,
    output logic       TRIG_A1,
    output logic       SCB_SCLK,
    output logic       SCB_MOSI,
    output logic       SCB_MCSn,
    output logic       ETH_RSTn,
    output logic       ETH_MDC,
    output logic       ETH_MDIO,
    output logic       DAC_SCLK,
    output logic       DAC_SDI,
    output logic       DAC_SYNC,
    output logic       L1_DAC_SCLK,
    output logic       L1_DAC_SDI,
    output logic       EEPROM_SCL,
    output logic       EEPROM_SDA,
    output logic       AD9222_SCLK,
    output logic       AD9222_SDIO,
    output logic       AD9222_CSBn
);

    // One counter is shared by INIT, STOP and READ; size it for the longest use.
    localparam int CNT_W = $clog2(2 * NSAMPLES + RESET_CYCLES + STOP_DELAY + 1);
    localparam int REF_W = $clog2(REFCLK_DIV + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_DELAY - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(2 * NSAMPLES);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFCLK_DIV - 1);
    localparam logic [3:0]       READ_ADDR = 4'b1011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_LOCK,
        ST_DOMINO,
        ST_STOP,
        ST_READ
    } state_t;

    logic rst;
    logic locked;
    logic trig;
    logic ext_edge;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             resetn_q, resetn_d;
    logic             denable_q, denable_d;
    logic             dwrite_q, dwrite_d;
    logic             rsrload_q, rsrload_d;
    logic             srclk_q, srclk_d;
    logic [3:0]       a_q, a_d;
    logic             bpout_q, bpout_d;
    logic             refclk_q, refclk_d;
    logic             adclk_q, adclk_d;
    logic             led0_q, led0_d;
    logic [15:0]      evt_q, evt_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             sync1_d, sync2_d, sync3_d;

    assign rst    = DIP_SWITCH[7];
    assign locked = (DRS_PLLLCK == 8'hFF);

    // Remaining DIP switch bits have no function on this board revision.
    logic unused_dip;
    assign unused_dip = &{1'b0, DIP_SWITCH[6:0]};

    // Trigger level synchronizer and rising-edge detector.
    always_comb begin
        sync1_d  = L1_OUT_P & ~L1_OUT_N;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        ext_edge = sync2_q & ~sync3_q;
    end

`ifdef DRS_AUTO_TRIG_EN
    localparam int AT_W = $clog2(AUTO_TRIG_PERIOD + 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_TRIG_PERIOD - 1);

    logic [AT_W-1:0] at_cnt_q, at_cnt_d;
    logic            auto_pulse;

    // Free-running period counter; the pulse bypasses the synchronizer so
    // it reaches the FSM two cycles sooner than an external edge.
    always_comb begin
        auto_pulse = (at_cnt_q == AT_LAST);
        at_cnt_d   = auto_pulse ? '0 : at_cnt_q + 1'b1;
        trig       = ext_edge | auto_pulse;
    end

    // Auto-trigger counter register.
    always_ff @(posedge OSC or posedge rst) begin
        if (rst) at_cnt_q <= '0;
        else     at_cnt_q <= at_cnt_d;
    end
`else
    localparam bit unused_auto_period = (AUTO_TRIG_PERIOD > 0);

    // Only the external L1 trigger is available in this build.
    always_comb begin
        trig = ext_edge;
    end
`endif

    // Free-running clock generators and lock LED.
    always_comb begin
        adclk_d   = ~adclk_q;
        led0_d    = locked;
        refclk_d  = refclk_q;
        ref_cnt_d = ref_cnt_q + 1'b1;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            refclk_d  = ~refclk_q;
        end
    end

    // Next-state and registered-output logic of the readout sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resetn_d  = resetn_q;
        denable_d = denable_q;
        dwrite_d  = dwrite_q;
        rsrload_d = 1'b0;
        srclk_d   = 1'b0;
        a_d       = a_q;
        bpout_d   = 1'b0;
        evt_d     = evt_q;
        case (state_q)
            ST_INIT: begin
                resetn_d  = 1'b0;
                denable_d = 1'b0;
                dwrite_d  = 1'b0;
                if (cnt_q == RST_LAST) begin
                    resetn_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                denable_d = 1'b0;
                dwrite_d  = 1'b0;
                a_d       = 4'd0;
                if (locked) begin
                    denable_d = 1'b1;
                    dwrite_d  = 1'b1;
                    state_d   = ST_DOMINO;
                end
            end
            ST_DOMINO: begin
                a_d = 4'd0;
                // Losing lock wins over a coincident trigger: the sampled
                // data would be unusable anyway.
                if (!locked) begin
                    denable_d = 1'b0;
                    dwrite_d  = 1'b0;
                    state_d   = ST_WAIT_LOCK;
                end else if (trig) begin
                    dwrite_d = 1'b0;
                    bpout_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    rsrload_d = 1'b1;
                    a_d       = READ_ADDR;
                    cnt_d     = '0;
                    state_d   = ST_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                // Even counts drive SRCLK high, odd counts low; the count
                // after the last low phase closes the event.
                if (cnt_q == READ_LAST) begin
                    evt_d = evt_q + 16'd1;
                    a_d   = 4'd0;
                    cnt_d = '0;
                    if (locked) begin
                        dwrite_d = 1'b1;
                        state_d  = ST_DOMINO;
                    end else begin
                        denable_d = 1'b0;
                        dwrite_d  = 1'b0;
                        state_d   = ST_WAIT_LOCK;
                    end
                end else begin
                    srclk_d = ~cnt_q[0];
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge OSC or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            resetn_q  <= 1'b0;
            denable_q <= 1'b0;
            dwrite_q  <= 1'b0;
            rsrload_q <= 1'b0;
            srclk_q   <= 1'b0;
            a_q       <= 4'd0;
            bpout_q   <= 1'b0;
            refclk_q  <= 1'b0;
            adclk_q   <= 1'b0;
            led0_q    <= 1'b0;
            evt_q     <= 16'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            resetn_q  <= resetn_d;
            denable_q <= denable_d;
            dwrite_q  <= dwrite_d;
            rsrload_q <= rsrload_d;
            srclk_q   <= srclk_d;
            a_q       <= a_d;
            bpout_q   <= bpout_d;
            refclk_q  <= refclk_d;
            adclk_q   <= adclk_d;
            led0_q    <= led0_d;
            evt_q     <= evt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
        end
    end

    assign DRS_RESETn   = {8{resetn_q}};
    assign DRS_DENABLE  = {8{denable_q}};
    assign DRS_DWRITE   = {8{dwrite_q}};
    assign DRS_RSRLOAD  = {8{rsrload_q}};
    assign DRS_SRCLK    = {8{srclk_q}};
    assign DRS_A0       = a_q;
    assign DRS_A1       = a_q;
    assign DRS_A2       = a_q;
    assign DRS_A3       = a_q;
    assign DRS_A4       = a_q;
    assign DRS_A5       = a_q;
    assign DRS_A6       = a_q;
    assign DRS_A7       = a_q;
    assign DRS_REFCLK_P = {8{refclk_q}};
    assign DRS_REFCLK_N = {8{~refclk_q}};
    assign AD9222_CLK_P = adclk_q;
    assign AD9222_CLK_N = ~adclk_q;
    assign TRIG_BPOUT_P = bpout_q;
    assign TRIG_BPOUT_N = ~bpout_q;
    assign LED          = {evt_q[0], led0_q};

    // Pins owned by sibling blocks, parked in their inactive state.
    assign DRS_WSRIN   = 8'h00;
    assign DRS_SRIN    = 8'h00;
    assign L0_CTR      = 1'b0;
    assign TRIG_A0     = 1'b0;
    assign TRIG_A1     = 1'b0;
    assign SCB_SCLK    = 1'b0;
    assign SCB_MOSI    = 1'b0;
    assign SCB_MCSn    = 1'b1;
    assign ETH_RSTn    = 1'b1;
    assign ETH_MDC     = 1'b0;
    assign ETH_MDIO    = 1'b0;
    assign DAC_SCLK    = 1'b0;
    assign DAC_SDI     = 1'b0;
    assign DAC_SYNC    = 1'b0;
    assign L1_DAC_SCLK = 1'b0;
    assign L1_DAC_SDI  = 1'b0;
    assign EEPROM_SCL  = 1'b0;
    assign EEPROM_SDA  = 1'b0;
    assign AD9222_SCLK = 1'b0;
    assign AD9222_SDIO = 1'b0;
    assign AD9222_CSBn = 1'b1;

endmodule

// File: tb/tb_dragon_v3_main_12.sv
// Testbench for dragon_v3_main_12 (default build, DRS_AUTO_TRIG_EN undefined).
// Expected values come from the timing rules of the readout: everything is
// expressed as a function of the cycle offset from the trigger-level rise.
module tb_dragon_v3_main_12;

    localparam int NS    = 1024;
    localparam int SD    = 8;
    localparam int RC    = 8;
    localparam int RDIV  = 25;
    localparam int T_FALL = 3;                       // DWRITE fall, edges after level rise
    localparam int T_LOAD = T_FALL + SD;             // RSRLOAD pulse
    localparam int T_SR0  = T_LOAD + 1;              // first SRCLK high
    localparam int T_END  = T_FALL + SD + 1 + 2 * NS; // DWRITE re-rise

    logic       OSC = 1'b0;
    logic [7:0] DIP_SWITCH = 8'h00;
    logic [7:0] DRS_PLLLCK = 8'h00;
    logic       L1_OUT_P = 1'b0;
    logic       L1_OUT_N = 1'b0;
    logic [7:0] DRS_RESETn, DRS_DENABLE, DRS_DWRITE, DRS_RSRLOAD, DRS_SRCLK;
    logic [3:0] DRS_A0, DRS_A1, DRS_A2, DRS_A3, DRS_A4, DRS_A5, DRS_A6, DRS_A7;
    logic [7:0] DRS_REFCLK_P, DRS_REFCLK_N;
    logic       AD9222_CLK_P, AD9222_CLK_N, TRIG_BPOUT_P, TRIG_BPOUT_N;
    logic [1:0] LED;
    logic [7:0] DRS_WSRIN, DRS_SRIN;
    logic       L0_CTR, TRIG_A0, TRIG_A1, SCB_SCLK, SCB_MOSI, SCB_MCSn;
    logic       ETH_RSTn, ETH_MDC, ETH_MDIO, DAC_SCLK, DAC_SDI, DAC_SYNC;
    logic       L1_DAC_SCLK, L1_DAC_SDI, EEPROM_SCL, EEPROM_SDA;
    logic       AD9222_SCLK, AD9222_SDIO, AD9222_CSBn;

    int tests  = 0;
    int fails  = 0;
    int ncyc   = 0;   // edges since reset release
    int events = 0;   // completed readouts since reset

    always #10 OSC = ~OSC;

    dragon_v3_main_12 dut (
        .OSC(OSC), .DIP_SWITCH(DIP_SWITCH), .DRS_PLLLCK(DRS_PLLLCK),
        .L1_OUT_P(L1_OUT_P), .L1_OUT_N(L1_OUT_N),
        .DRS_RESETn(DRS_RESETn), .DRS_DENABLE(DRS_DENABLE), .DRS_DWRITE(DRS_DWRITE),
        .DRS_RSRLOAD(DRS_RSRLOAD), .DRS_SRCLK(DRS_SRCLK),
        .DRS_A0(DRS_A0), .DRS_A1(DRS_A1), .DRS_A2(DRS_A2), .DRS_A3(DRS_A3),
        .DRS_A4(DRS_A4), .DRS_A5(DRS_A5), .DRS_A6(DRS_A6), .DRS_A7(DRS_A7),
        .DRS_REFCLK_P(DRS_REFCLK_P), .DRS_REFCLK_N(DRS_REFCLK_N),
        .AD9222_CLK_P(AD9222_CLK_P), .AD9222_CLK_N(AD9222_CLK_N),
        .TRIG_BPOUT_P(TRIG_BPOUT_P), .TRIG_BPOUT_N(TRIG_BPOUT_N), .LED(LED),
        .DRS_WSRIN(DRS_WSRIN), .DRS_SRIN(DRS_SRIN), .L0_CTR(L0_CTR),
        .TRIG_A0(TRIG_A0), .TRIG_A1(TRIG_A1), .SCB_SCLK(SCB_SCLK),
        .SCB_MOSI(SCB_MOSI), .SCB_MCSn(SCB_MCSn), .ETH_RSTn(ETH_RSTn),
        .ETH_MDC(ETH_MDC), .ETH_MDIO(ETH_MDIO), .DAC_SCLK(DAC_SCLK),
        .DAC_SDI(DAC_SDI), .DAC_SYNC(DAC_SYNC), .L1_DAC_SCLK(L1_DAC_SCLK),
        .L1_DAC_SDI(L1_DAC_SDI), .EEPROM_SCL(EEPROM_SCL), .EEPROM_SDA(EEPROM_SDA),
        .AD9222_SCLK(AD9222_SCLK), .AD9222_SDIO(AD9222_SDIO), .AD9222_CSBn(AD9222_CSBn)
    );

    function automatic logic [7:0] b8(input bit v);
        return v ? 8'hFF : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_drs(input string tag, input bit resetn, input bit denable,
                             input bit dwrite, input bit rsrload, input bit srclk,
                             input logic [3:0] a, input bit bpout);
        check({tag, "_resetn"},  DRS_RESETn,   b8(resetn));
        check({tag, "_denable"}, DRS_DENABLE,  b8(denable));
        check({tag, "_dwrite"},  DRS_DWRITE,   b8(dwrite));
        check({tag, "_rsrload"}, DRS_RSRLOAD,  b8(rsrload));
        check({tag, "_srclk"},   DRS_SRCLK,    b8(srclk));
        check({tag, "_a0"},      DRS_A0,       a);
        check({tag, "_a7"},      DRS_A7,       a);
        check({tag, "_bpout_p"}, TRIG_BPOUT_P, bpout);
        check({tag, "_bpout_n"}, TRIG_BPOUT_N, !bpout);
    endtask

    // One OSC edge; free-running clocks and LEDs are checked on every edge.
    task automatic tick();
        bit lk;
        lk = (DRS_PLLLCK == 8'hFF);
        @(posedge OSC);
        #1;
        ncyc++;
        check("refclk_p", DRS_REFCLK_P, b8(((ncyc / RDIV) % 2) == 1));
        check("refclk_n", DRS_REFCLK_N, b8(((ncyc / RDIV) % 2) == 0));
        check("adclk_p",  AD9222_CLK_P, ncyc % 2);
        check("adclk_n",  AD9222_CLK_N, (ncyc + 1) % 2);
        check("led0",     LED[0], lk);
        check("led1",     LED[1], events % 2);
    endtask

    // Edge o after the trigger level rose while in DOMINO.
    task automatic step_event(input int o, input bit end_unlocked);
        bit in_ro, after;
        int rel;
        if (o == T_END) events++;
        tick();
        in_ro = (o >= T_FALL) && (o < T_END);
        after = (o >= T_END);
        rel   = o - T_SR0;
        check_drs("evt", 1'b1,
                  !(after && end_unlocked),
                  !in_ro && !(after && end_unlocked),
                  o == T_LOAD,
                  (rel >= 0) && (rel < 2 * NS) && (rel % 2 == 0),
                  ((o >= T_LOAD) && (o < T_END)) ? 4'b1011 : 4'b0000,
                  o == T_FALL);
    endtask

    // mode 0: single trigger; 1: extra trigger edge during STOP/READ;
    // 2: PLL lock lost during READ, readout completes then waits for lock.
    task automatic run_event(input int mode);
        int r;
        r = $urandom_range(12, 1500);
        L1_OUT_P = 1'b1;
        L1_OUT_N = 1'b0;
        for (int o = 1; o <= T_END + 2; o++) begin
            if (o == 20) L1_OUT_P = 1'b0;
            if (mode == 1 && o == r + 20) L1_OUT_P = 1'b1;
            if (mode == 1 && o == r + 30) L1_OUT_P = 1'b0;
            if (mode == 2 && o == 100) DRS_PLLLCK = 8'($urandom_range(0, 254));
            step_event(o, mode == 2);
        end
        $display("[TB] event mode %0d complete, events=%0d, cycle %0d", mode, events, ncyc);
    endtask

    task automatic init_sequence(input bit pll_ok);
        for (int k = 1; k <= RC; k++) begin
            tick();
            check_drs("init", k >= RC, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        if (pll_ok) begin
            tick();
            check_drs("relock", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_drs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check({tag, "_refclk_p"}, DRS_REFCLK_P, 8'h00);
        check({tag, "_adclk_p"},  AD9222_CLK_P, 1'b0);
        check({tag, "_led"},      LED, 2'b00);
    endtask

    initial begin
        int n;
        // Reset pulse of 100 ns with PLL unlocked.
        #2 DIP_SWITCH = 8'h80;
        #58;
        check_reset_values("rst");
        check("eth_rstn",  ETH_RSTn, 1'b1);
        check("scb_mcsn",  SCB_MCSn, 1'b1);
        check("ad_csbn",   AD9222_CSBn, 1'b1);
        check("drs_srin",  DRS_SRIN, 8'h00);
        check("drs_wsrin", DRS_WSRIN, 8'h00);
        check("a3",        DRS_A3, 4'd0);
        #40 DIP_SWITCH = 8'h00;   // t = 100 ns, on a falling edge
        ncyc = 0;
        events = 0;
        init_sequence(1'b0);

        // WAIT_LOCK holds while unlocked; trigger edges here are dropped.
        n = $urandom_range(10, 40);
        for (int i = 0; i < n; i++) begin
            if (i == 2) L1_OUT_P = 1'b1;
            if (i == 8) L1_OUT_P = 1'b0;
            tick();
            check_drs("wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // Lock acquired: domino starts on the next edge.
        DRS_PLLLCK = 8'hFF;
        n = $urandom_range(5, 20);
        for (int i = 0; i < n; i++) begin
            tick();
            check_drs("domino", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // P and N both high is not a trigger level.
        L1_OUT_P = 1'b1;
        L1_OUT_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_drs("pn_both", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        L1_OUT_P = 1'b0;
        L1_OUT_N = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        run_event(0);
        run_event(1);
        run_event(2);

        // Lock restored after the readout that ended unlocked.
        DRS_PLLLCK = 8'hFF;
        tick();
        check_drs("relock2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Lock drop during DOMINO stops sampling; recovery resumes it.
        DRS_PLLLCK = 8'($urandom_range(0, 254));
        n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) begin
            tick();
            check_drs("lockdrop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        DRS_PLLLCK = 8'hFF;
        tick();
        check_drs("lockback", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();

        // Reset in the middle of READ while SRCLK is high.
        n = T_SR0 + 2 * $urandom_range(0, NS - 1);
        L1_OUT_P = 1'b1;
        for (int o = 1; o <= n; o++) begin
            if (o == 20) L1_OUT_P = 1'b0;
            step_event(o, 1'b0);
        end
        #3 DIP_SWITCH = 8'h80;
        #1;
        check_reset_values("midread_rst");
        @(negedge OSC);
        L1_OUT_P = 1'b0;
        DIP_SWITCH = 8'h00;
        ncyc = 0;
        events = 0;
        init_sequence(1'b1);
        for (int i = 0; i < 3; i++) tick();
        run_event(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
